// File: rtl/random_pulse_monitor.sv
// random_pulse_monitor: per-window pulse count, min/max inter-pulse interval and sticky rate flags.
// Optional alarm output enabled by defining RANDOM_PULSE_MONITOR_ALARM_EN.
`default_nettype none

module random_pulse_monitor #(
   parameter int WINDOW_LN2 = 8,
   parameter int CNT_W      = 16,
   parameter int INT_W      = 16,
   parameter int MIN_COUNT  = 8,
   parameter int MAX_COUNT  = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             pulse_in,
   input  logic             clear,
   output logic [CNT_W-1:0] window_count,
   output logic             window_valid,
   output logic [INT_W-1:0] min_interval,
   output logic [INT_W-1:0] max_interval,
   output logic             rate_low,
`ifdef RANDOM_PULSE_MONITOR_ALARM_EN
   output logic             alarm,
`endif
   output logic             rate_high
);

   typedef enum logic {WAIT_FIRST = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
   localparam logic [INT_W-1:0] INT_ONES = {INT_W{1'b1}};
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_COUNT);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);

   state_t                state;
   logic [WINDOW_LN2-1:0] pos;
   logic [CNT_W-1:0]      run_cnt;
   logic [INT_W-1:0]      ivl;
   logic                  prev;

   logic                  pulse_event;
   logic                  terminal;
   logic [CNT_W-1:0]      cnt_next;

   always_comb begin
      pulse_event = ce & pulse_in & ~prev;
      terminal    = &pos;
      cnt_next    = (pulse_event && (run_cnt != CNT_ONES)) ? run_cnt + 1'b1 : run_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= WAIT_FIRST;
         pos          <= '0;
         run_cnt      <= '0;
         ivl          <= '0;
         prev         <= 1'b0;
         window_count <= '0;
         window_valid <= 1'b0;
         min_interval <= INT_ONES;
         max_interval <= '0;
         rate_low     <= 1'b0;
         rate_high    <= 1'b0;
`ifdef RANDOM_PULSE_MONITOR_ALARM_EN
         alarm        <= 1'b0;
`endif
      end else begin
         window_valid <= 1'b0;
         // prev keeps tracking through clear so a held level is not recounted
         if (ce)
            prev <= pulse_in;
`ifdef RANDOM_PULSE_MONITOR_ALARM_EN
         alarm <= clear ? 1'b0 : (rate_low | rate_high);
`endif
         if (clear) begin
            state        <= WAIT_FIRST;
            pos          <= '0;
            run_cnt      <= '0;
            ivl          <= '0;
            window_count <= '0;
            min_interval <= INT_ONES;
            max_interval <= '0;
            rate_low     <= 1'b0;
            rate_high    <= 1'b0;
         end else if (ce) begin
            pos <= pos + 1'b1;
            if (terminal) begin
               window_count <= cnt_next;
               window_valid <= 1'b1;
               run_cnt      <= '0;
               if (cnt_next < MIN_C)
                  rate_low <= 1'b1;
               if (cnt_next > MAX_C)
                  rate_high <= 1'b1;
            end else begin
               run_cnt <= cnt_next;
            end

            case (state)
               WAIT_FIRST: begin
                  if (pulse_event) begin
                     ivl   <= {{(INT_W-1){1'b0}}, 1'b1};
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (pulse_event) begin
                     if (ivl < min_interval)
                        min_interval <= ivl;
                     if (ivl > max_interval)
                        max_interval <= ivl;
                     ivl <= {{(INT_W-1){1'b0}}, 1'b1};
                  end else if (ivl != INT_ONES) begin
                     ivl <= ivl + 1'b1;
                  end
               end
               default: state <= WAIT_FIRST;
            endcase
         end
      end
   end

endmodule

`default_nettype wire
